// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the I/O responder.
// FSM state type, request op-codes, BCD digit width and double-dabble
// step helper used by io_responder and its button front end.
package io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    CONVERT,
    DONE
  } ioState_t;

  localparam logic [1:0] IO_OP_IN  = 2'b01;
  localparam logic [1:0] IO_OP_OUT = 2'b10;

  localparam int BCD_W      = 4;
  localparam int CONV_ITERS = 10;
  localparam int BIN_W      = 10;
  localparam int DAB_W      = 3 * BCD_W + BIN_W;

  typedef logic [DAB_W-1:0] dabble_t;

  // One shift-add-3 iteration: correct every BCD digit >= 5, then shift the
  // whole {hundreds, tens, units, binary} vector left by one.
  function automatic dabble_t dabbleStep(input dabble_t cur);
    dabble_t tmp;
    tmp = cur;
    for (int d = 0; d < 3; d++) begin
      if (tmp[BIN_W + d*BCD_W +: BCD_W] >= 4'd5) begin
        tmp[BIN_W + d*BCD_W +: BCD_W] = tmp[BIN_W + d*BCD_W +: BCD_W] + 4'd3;
      end
    end
    return tmp << 1;
  endfunction

endpackage

// File: rtl/botao_debounce.sv
// botao_debounce: two-flop synchronizer for the raw push button plus an
// optional stability filter. Only the stable level leaves this block; the
// responder FSM decides what a press or release means.
// Build option: define IO_DEBOUNCE_EN to require DEBOUNCE_CYCLES consecutive
// differing synchronized samples before the output level follows the pin.
module botao_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic botao,
  output logic level
);

  logic syncMeta;
  logic syncOut;

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
    end else begin
      syncMeta <= botao;
      syncOut  <= syncMeta;
    end
  end

  if (DEBOUNCE_CYCLES < 1) begin : gBadCycles
    $error("botao_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cntReg;
  logic             stableReg;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so short glitches never get through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntReg    <= '0;
      stableReg <= 1'b0;
    end else if (syncOut == stableReg) begin
      cntReg <= '0;
    end else if (cntReg == CNT_LAST) begin
      stableReg <= syncOut;
      cntReg    <= '0;
    end else begin
      cntReg <= cntReg + CNT_W'(1);
    end
  end

  assign level = stableReg;
`else
  assign level = syncOut;
`endif

endmodule

// File: rtl/io_responder.sv
// io_responder: CPU I/O request responder. IN waits for one full button
// press/release and returns the switch bank; OUT converts a value to three
// BCD digits (saturating to 999 with ovf above DISP_MAX); other op-codes
// complete immediately. Build option IO_DEBOUNCE_EN enables the button filter.
module io_responder
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DISP_MAX        = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_data,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             cpu_stall,
  input  logic             botao,
  input  logic [3:0]       chaves,
  output logic [BCD_W-1:0] unidade,
  output logic [BCD_W-1:0] dezena,
  output logic [BCD_W-1:0] centena,
  output logic             ovf
);

  localparam int ITER_W = $clog2(CONV_ITERS);

  ioState_t          stateReg, stateNext;
  dabble_t           dabbleReg, dabbleNext, dabbleStepped;
  logic [ITER_W-1:0] iterReg, iterNext;
  logic [3:0]        inDataReg, inDataNext;
  logic [BCD_W-1:0]  uniReg, uniNext, dezReg, dezNext, cenReg, cenNext;
  logic              ovfReg, ovfNext;
  logic              rspValidReg, rspValidNext;
  logic              stallReg, stallNext;
  logic              btnLevel;

  botao_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebounce (
    .clk  (clk),
    .reset(reset),
    .botao(botao),
    .level(btnLevel)
  );

  assign dabbleStepped = dabbleStep(dabbleReg);

  // State and datapath registers; everything clears on reset so an in-flight
  // request is dropped without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      dabbleReg   <= '0;
      iterReg     <= '0;
      inDataReg   <= '0;
      uniReg      <= '0;
      dezReg      <= '0;
      cenReg      <= '0;
      ovfReg      <= 1'b0;
      rspValidReg <= 1'b0;
      stallReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      dabbleReg   <= dabbleNext;
      iterReg     <= iterNext;
      inDataReg   <= inDataNext;
      uniReg      <= uniNext;
      dezReg      <= dezNext;
      cenReg      <= cenNext;
      ovfReg      <= ovfNext;
      rspValidReg <= rspValidNext;
      stallReg    <= stallNext;
    end
  end

  // Next-state and datapath updates; requests are only looked at in IDLE.
  always_comb begin
    stateNext    = stateReg;
    dabbleNext   = dabbleReg;
    iterNext     = iterReg;
    inDataNext   = inDataReg;
    uniNext      = uniReg;
    dezNext      = dezReg;
    cenNext      = cenReg;
    ovfNext      = ovfReg;
    rspValidNext = 1'b0;
    stallNext    = stallReg;

    // The stall covers the response cycle itself and drops right after it.
    if (rspValidReg) begin
      stallNext = 1'b0;
    end

    case (stateReg)
      IDLE: begin
        if (req_valid) begin
          inDataNext = '0;
          if (req_op == IO_OP_IN) begin
            stateNext = WAIT_PRESS;
            stallNext = 1'b1;
          end else if (req_op == IO_OP_OUT) begin
            if (req_data > 32'(DISP_MAX)) begin
              uniNext   = 4'd9;
              dezNext   = 4'd9;
              cenNext   = 4'd9;
              ovfNext   = 1'b1;
              stateNext = DONE;
            end else begin
              dabbleNext = {{(3*BCD_W){1'b0}}, req_data[BIN_W-1:0]};
              iterNext   = '0;
              stateNext  = CONVERT;
            end
          end else begin
            stateNext = DONE;
          end
        end
      end
      WAIT_PRESS: begin
        if (btnLevel) begin
          inDataNext = chaves;
          stateNext  = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!btnLevel) begin
          stateNext = DONE;
        end
      end
      CONVERT: begin
        dabbleNext = dabbleStepped;
        iterNext   = iterReg + ITER_W'(1);
        // Digits are published only from the final iteration so the
        // displays never show a partial conversion.
        if (iterReg == ITER_W'(CONV_ITERS - 1)) begin
          uniNext   = dabbleStepped[BIN_W +: BCD_W];
          dezNext   = dabbleStepped[BIN_W + BCD_W +: BCD_W];
          cenNext   = dabbleStepped[BIN_W + 2*BCD_W +: BCD_W];
          ovfNext   = 1'b0;
          stateNext = DONE;
        end
      end
      DONE: begin
        rspValidNext = 1'b1;
        stateNext    = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign req_ready = (stateReg == IDLE);
  assign rsp_valid = rspValidReg;
  assign rsp_data  = {28'd0, inDataReg};
  assign cpu_stall = stallReg;
  assign unidade   = uniReg;
  assign dezena    = dezReg;
  assign centena   = cenReg;
  assign ovf       = ovfReg;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed, table-driven bench for io_responder.
// Works in both builds; IN timing expectations follow IO_DEBOUNCE_EN.
module tb_io_responder;

`ifdef IO_DEBOUNCE_EN
  localparam int IN1_LATCH = 11;
  localparam int IN1_PULSE = 18;
  localparam int IN2_PULSE = 13;
`else
  localparam int IN1_LATCH = 3;
  localparam int IN1_PULSE = 5;
  localparam int IN2_PULSE = 9;
`endif

  localparam logic [1:0] OP_IN  = 2'b01;
  localparam logic [1:0] OP_OUT = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        cpu_stall;
  logic        botao;
  logic [3:0]  chaves;
  logic [3:0]  unidade, dezena, centena;
  logic        ovf;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          lat;
    logic [11:0] dig;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  io_responder #(
    .DEBOUNCE_CYCLES(4),
    .DISP_MAX(999)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .cpu_stall(cpu_stall),
    .botao    (botao),
    .chaves   (chaves),
    .unidade  (unidade),
    .dezena   (dezena),
    .centena  (centena),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] digits();
    return {centena, dezena, unidade};
  endfunction

  task automatic runVec(input string name, input logic [1:0] op, input logic [31:0] data,
                        input int lat, input logic [11:0] expDig, input logic expOvf,
                        input logic [11:0] prevDig, input logic prevOvf);
    int seen;
    bit held;
    seen = 0;
    held = 1'b1;
    req_op    = op;
    req_data  = data;
    req_valid = 1'b1;
    check({name, "/ready_idle"}, 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    check({name, "/ready_busy"}, 32'(req_ready), 32'd0);
    check({name, "/stall"}, 32'(cpu_stall), 32'd0);
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      if (k - 1 < lat - 1 && (digits() !== prevDig || ovf !== prevOvf)) held = 1'b0;
      tick;
      if (rsp_valid === 1'b1) seen = k;
    end
    check({name, "/latency"}, 32'(seen), 32'(lat));
    check({name, "/digits"}, 32'(digits()), 32'(expDig));
    check({name, "/ovf"}, 32'(ovf), 32'(expOvf));
    check({name, "/rsp_data"}, rsp_data, 32'd0);
    check({name, "/digits_held"}, 32'(held), 32'd1);
    tick;
    check({name, "/pulse_width"}, 32'(rsp_valid), 32'd0);
    check({name, "/ready_after"}, 32'(req_ready), 32'd1);
    $display("txn %s op=%0d data=%0d latency=%0d digits=%03h ovf=%0b",
             name, op, data, seen, digits(), ovf);
  endtask

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic [11:0] curDig;
    logic        curOvf;
    logic [15:0] pat;
    int          pulseIdx, pulseCnt, m;
    bit          stallOk, readyOk, noRsp;

    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_data = '0;
    botao = 1'b0; chaves = 4'h0;

    vecs[0]  = '{OP_OUT, 32'd473,        11, 12'h473, 1'b0};
    vecs[1]  = '{OP_OUT, 32'd1000,        1, 12'h999, 1'b1};
    vecs[2]  = '{2'b00,  32'd77,          1, 12'h999, 1'b1};
    vecs[3]  = '{OP_OUT, 32'd5,          11, 12'h005, 1'b0};
    vecs[4]  = '{2'b11,  32'd123,         1, 12'h005, 1'b0};
    vecs[5]  = '{OP_OUT, 32'd999,        11, 12'h999, 1'b0};
    vecs[6]  = '{OP_OUT, 32'd0,          11, 12'h000, 1'b0};
    vecs[7]  = '{OP_OUT, 32'hFFFF_FFFF,   1, 12'h999, 1'b1};
    vecs[8]  = '{OP_OUT, 32'd998,        11, 12'h998, 1'b0};
    vecs[9]  = '{OP_OUT, 32'd1023,        1, 12'h999, 1'b1};
    vecs[10] = '{OP_OUT, 32'h0001_01D9,   1, 12'h999, 1'b1};
    vecs[11] = '{OP_OUT, 32'd60,         11, 12'h060, 1'b0};

    // Reset state
    repeat (3) tick;
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rsp_data", rsp_data, 32'd0);
    check("reset/cpu_stall", 32'(cpu_stall), 32'd0);
    check("reset/digits", 32'(digits()), 32'd0);
    check("reset/ovf", 32'(ovf), 32'd0);
    $display("txn reset digits=%03h ovf=%0b ready=%0b", digits(), ovf, req_ready);
    reset = 1'b1;
    repeat (2) tick;

    // Table of OUT / no-op transactions
    curDig = 12'h000;
    curOvf = 1'b0;
    for (int i = 0; i < 12; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].lat,
             vecs[i].dig, vecs[i].ovf, curDig, curOvf);
      curDig = vecs[i].dig;
      curOvf = vecs[i].ovf;
    end

    // IN with a bouncing button: 1,0,1,0 glitches, 6 cycles high, 6 low
    pat = 16'h03F5;
    chaves = 4'hA;
    req_op = OP_IN; req_data = 32'hFFFF_FFFF; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    check("in1/stall_start", 32'(cpu_stall), 32'd1);
    pulseIdx = 0; pulseCnt = 0; stallOk = 1'b1;
    for (int k = 0; k < 30; k++) begin
      botao = (k < 16) ? pat[k] : 1'b0;
      tick;
      m = k + 1;
      if (m == IN1_LATCH - 1) check("in1/no_early_latch", rsp_data, 32'd0);
      if (m == IN1_LATCH) check("in1/latch", rsp_data, 32'h0000_000A);
      if (rsp_valid === 1'b1) begin
        pulseCnt++;
        if (pulseIdx == 0) pulseIdx = m;
      end
      if ((pulseIdx == 0 || m == pulseIdx) ? (cpu_stall !== 1'b1) : (cpu_stall !== 1'b0))
        stallOk = 1'b0;
    end
    check("in1/pulse_cycle", 32'(pulseIdx), 32'(IN1_PULSE));
    check("in1/pulse_count", 32'(pulseCnt), 32'd1);
    check("in1/rsp_data", rsp_data, 32'h0000_000A);
    check("in1/stall_window", 32'(stallOk), 32'd1);
    check("in1/digits_kept", 32'(digits()), 32'(curDig));
    check("in1/ovf_kept", 32'(ovf), 32'(curOvf));
    $display("txn in1 chaves=A pulse_cycle=%0d pulses=%0d rsp_data=%0h", pulseIdx, pulseCnt, rsp_data);

    // IN with the button already held at acceptance; switches change after latch
    botao = 1'b1;
    repeat (10) tick;
    chaves = 4'h3;
    req_op = OP_IN; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    pulseIdx = 0;
    for (int k = 0; k < 25; k++) begin
      if (k == 3) chaves = 4'hC;
      if (k == 5) botao = 1'b0;
      tick;
      m = k + 1;
      if (rsp_valid === 1'b1 && pulseIdx == 0) pulseIdx = m;
    end
    check("in2/pulse_cycle", 32'(pulseIdx), 32'(IN2_PULSE));
    check("in2/rsp_data", rsp_data, 32'h0000_0003);
    check("in2/stall_after", 32'(cpu_stall), 32'd0);
    $display("txn in2 held press pulse_cycle=%0d rsp_data=%0h", pulseIdx, rsp_data);

    // Second request while converting is ignored
    req_op = OP_OUT; req_data = 32'd473; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    pulseIdx = 0; pulseCnt = 0; readyOk = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k >= 2 && k <= 4) begin
        req_valid = 1'b1; req_op = OP_OUT; req_data = 32'd5;
        if (req_ready !== 1'b0) readyOk = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      tick;
      m = k + 1;
      if (rsp_valid === 1'b1) begin
        pulseCnt++;
        if (pulseIdx == 0) pulseIdx = m;
      end
    end
    check("busy/ready_low", 32'(readyOk), 32'd1);
    check("busy/pulse_count", 32'(pulseCnt), 32'd1);
    check("busy/pulse_cycle", 32'(pulseIdx), 32'd11);
    check("busy/digits", 32'(digits()), 32'h473);
    $display("txn busy second_req ignored pulses=%0d digits=%03h", pulseCnt, digits());

    // Reset while waiting for a press
    req_op = OP_IN; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (2) tick;
    check("rst/stall_before", 32'(cpu_stall), 32'd1);
    reset = 1'b0;
    #1;
    check("rst/req_ready", 32'(req_ready), 32'd1);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/rsp_data", rsp_data, 32'd0);
    check("rst/cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst/digits", 32'(digits()), 32'd0);
    check("rst/ovf", 32'(ovf), 32'd0);
    repeat (3) tick;
    reset = 1'b1;
    noRsp = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (rsp_valid !== 1'b0) noRsp = 1'b0;
    end
    check("rst/no_rsp", 32'(noRsp), 32'd1);
    $display("txn reset_mid_in ready=%0b stall=%0b digits=%03h", req_ready, cpu_stall, digits());
    runVec("post_reset", OP_OUT, 32'd12, 11, 12'h012, 1'b0, 12'h000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a button level change.
REQ-002 Parameter DISP_MAX, default 999: largest value shown without saturation.
REQ-003 clock  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  CPU I/O request strobe.
REQ-006 req_op  in  2  01=IN (read switches), 10=OUT (display); 00/11=no-op.
REQ-007 req_data  in  32  value to display on OUT.
REQ-008 req_ready  out  1  high only in IDLE.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_data  out  32  IN result: switches zero-extended; 0 for OUT and no-op.
REQ-011 cpu_stall  out  1  high from IN acceptance until rsp_valid, inclusive.
REQ-012 botao  in  1  raw, asynchronous push button, active-high.
REQ-013 chaves  in  4  switch bank, quasi-static.
REQ-014 unidade, dezena, centena  out  4 each  BCD digits for the displays.
REQ-015 ovf  out  1  last OUT value exceeded DISP_MAX.

Function
REQ-016 FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, CONVERT, DONE.
REQ-017 Handshake: accept when req_valid && req_ready; capture req_op/req_data; req_valid outside IDLE is ignored (no queueing).
REQ-018 IN: IDLE->WAIT_PRESS; on debounced press, latch chaves into rsp_data[3:0] -> WAIT_RELEASE; on debounced release -> DONE.
REQ-019 Press already held at acceptance: WAIT_PRESS still needs the debounced level high; release must then be seen before completion (one press = one IN).
REQ-020 OUT, req_data <= DISP_MAX: IDLE->CONVERT; 10-iteration shift-add-3 (double-dabble) on req_data[9:0], one iteration per cycle; then DONE.
REQ-021 OUT, req_data > DISP_MAX: skip CONVERT; digits 9,9,9; ovf=1; go to DONE on the next edge.
REQ-022 OUT in range: ovf cleared; all three digits update together on the edge entering DONE, never mid-conversion.
REQ-023 Latency: rsp_valid high in the cycle after entering DONE. In-range OUT: 11 cycles after the acceptance edge. Saturated OUT and no-op: 1 cycle.
REQ-024 DONE->IDLE unconditionally after one cycle; rsp_valid is exactly one cycle wide.
REQ-025 No-op: IDLE->DONE; rsp_data=0; digits and ovf unchanged.
REQ-026 IN leaves digits and ovf unchanged; OUT leaves the latched IN data cleared (rsp_data=0).
REQ-027 botao passes through a 2-flop synchronizer before any use.

Reset
REQ-028 reset low forces at once: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, cpu_stall=0, digits=0, ovf=0, debounce counter=0, synchronizer=0.
REQ-029 Reset mid-operation abandons the request with no rsp_valid. The first request after reset release is accepted normally.

Configuration
REQ-030 Macro IO_DEBOUNCE_EN defined: DEBOUNCE_CYCLES filtering per REQ-001.
REQ-031 IO_DEBOUNCE_EN undefined: the synchronized level is used directly (press/release seen 2 cycles after the pin change); DEBOUNCE_CYCLES is ignored.

Structure
REQ-032 Shared package io_pkg holds:
- FSM state typedef
- op-code constants IO_OP_IN, IO_OP_OUT
- BCD digit width
- CONVERT iteration count (10)
REQ-033 Sub-module botao_debounce holds the synchronizer and the optional filter; it outputs the stable level only; the FSM detects edges.

Verification
REQ-034 OUT req_data=473 -> 11 cycles later: rsp_valid pulse, centena=4, dezena=7, unidade=3, ovf=0.
REQ-035 OUT req_data=1000 -> next cycle: rsp_valid, digits 9/9/9, ovf=1; then OUT 5 -> digits 0/0/5, ovf=0.
REQ-036 IN with chaves=4'hA; botao bounces 1-0-1 in 1-cycle glitches, then holds high 6 cycles, then low 6 cycles -> no early latch; rsp_data=32'h0000000A after release; cpu_stall high throughout.
REQ-037 Second req_valid during CONVERT -> ignored, req_ready=0, exactly one rsp_valid.
REQ-038 reset low during WAIT_PRESS -> all outputs at reset values, no rsp_valid; a following OUT 12 -> digits 0/1/2.
